// File: rtl/mdll_pkg.sv
// mdll_pkg: shared encodings, default widths and width helpers for the MDLL loop filter
package mdll_pkg;
    localparam logic LOOP_BB  = 1'b1;
    localparam logic LOOP_TDC = 1'b0;
    typedef enum logic [1:0] {ZERO = 2'd0, POS = 2'd1, NEG = 2'd2} sgn_t;
    localparam int MTUNE_W_DEF = 7;
    localparam int FRAC_W_DEF  = 6;
    localparam int TDC_W_DEF   = 4;
    localparam int GAIN_W_DEF  = 4;
    localparam int LOCK_N_DEF  = 16;
    // two guard bits let the tune code swing by +/-3 before clamping
    localparam int MT_GUARD = 2;
    function automatic int acc_w(input int mtune_w, input int frac_w);
        return mtune_w + frac_w;
    endfunction
    function automatic int sum_w(input int acc_bits, input int tdc_w);
        return acc_bits + tdc_w + 1;
    endfunction
endpackage

// File: rtl/mdll_dsm1.sv
// mdll_dsm1: first-order delta-sigma modulator turning the integrator fraction into a 1-bit dither
module mdll_dsm1 #(
    parameter int FRAC_W = 6
) (
    input  logic              clk_err,
    input  logic              rstb,
    input  logic [FRAC_W-1:0] frac,
    input  logic              en,
    input  logic              hold,
    output logic              dither
);
    logic [FRAC_W-1:0] dsm;
    logic [FRAC_W:0]   sum;
    assign sum = {1'b0, dsm} + {1'b0, frac};
    // a frozen loop keeps the modulator phase; otherwise disabling clears it
    always_ff @(posedge clk_err or negedge rstb) begin
        if (!rstb) begin
            dsm    <= '0;
            dither <= 1'b0;
        end else if (!hold) begin
            dsm    <= en ? sum[FRAC_W-1:0] : '0;
            dither <= en & sum[FRAC_W];
        end
    end
endmodule

// File: rtl/mdll_lf_gen.sv
// mdll_lf_gen: MDLL digital loop filter -- BB/TDC error integrator, proportional kick,
// external tune override, dither and lock detection
module mdll_lf_gen
    import mdll_pkg::*;
#(
    parameter int MTUNE_W = MTUNE_W_DEF,
    parameter int FRAC_W  = FRAC_W_DEF,
    parameter int TDC_W   = TDC_W_DEF,
    parameter int GAIN_W  = GAIN_W_DEF,
    parameter int LOCK_N  = LOCK_N_DEF
) (
    input  logic                      clk_err,
    input  logic                      rstb,
    input  logic                      en_lf,
    input  logic                      loop_sel,
    input  logic                      err_valid,
    input  logic                      dout_bb,
    input  logic [TDC_W-1:0]          tdc_err,
    input  logic [GAIN_W-1:0]         gain_ctrl,
    input  logic [1:0]                gain_ratio,
    input  logic                      en_ext_tune,
    input  logic [MTUNE_W-1:0]        ext_mtune,
    input  logic                      en_dith,
    output logic [MTUNE_W-1:0]        mtune,
    output logic [MTUNE_W+FRAC_W-1:0] lf_out,
    output logic                      dither,
    output logic                      locked,
    output logic                      sat_hi,
    output logic                      sat_lo
);
    localparam int ACC_W = acc_w(MTUNE_W, FRAC_W);
    localparam int SUM_W = sum_w(ACC_W, TDC_W);
    localparam int MT_W  = MTUNE_W + MT_GUARD;
    localparam int CNT_W = $clog2(LOCK_N + 1);
    localparam logic signed [SUM_W-1:0] ACC_MAX = SUM_W'((64'd1 << ACC_W) - 64'd1);
    localparam logic signed [MT_W-1:0]  MT_MAX  = MT_W'((64'd1 << MTUNE_W) - 64'd1);
    localparam logic [ACC_W-1:0]        ACC_RST = ACC_W'(64'd1 << (ACC_W - 1));
    logic [ACC_W-1:0]        acc, acc_nx;
    logic signed [SUM_W-1:0] e_x, sum;
    logic [GAIN_W-1:0]       sh;
    logic signed [MT_W-1:0]  mt_sum, ratio_x;
    logic [MTUNE_W-1:0]      mt_nx;
    logic [CNT_W-1:0]        lock_cnt, cnt_nx;
    sgn_t                    sg, prev_sg;
    logic                    clamp_hi, clamp_lo, alt;
    always_comb begin
        e_x      = (loop_sel == LOOP_BB) ? (dout_bb ? SUM_W'(1) : {SUM_W{1'b1}}) : SUM_W'(signed'(tdc_err));
        sh       = (32'(gain_ctrl) > ACC_W - 1) ? GAIN_W'(ACC_W - 1) : gain_ctrl;
        sum      = signed'(SUM_W'(acc)) + (e_x <<< sh);
        clamp_lo = sum[SUM_W-1];
        clamp_hi = !clamp_lo && (sum > ACC_MAX);
        acc_nx   = clamp_lo ? '0 : clamp_hi ? '1 : sum[ACC_W-1:0];
        sg       = e_x[SUM_W-1] ? NEG : (e_x == '0) ? ZERO : POS;
        ratio_x  = signed'(MT_W'(gain_ratio));
        mt_sum   = signed'(MT_W'(acc_nx[ACC_W-1 -: MTUNE_W])) + ((sg == POS) ? ratio_x : (sg == NEG) ? -ratio_x : '0);
        mt_nx    = mt_sum[MT_W-1] ? '0 : (mt_sum > MT_MAX) ? '1 : mt_sum[MTUNE_W-1:0];
        // ZERO as the previous sign means no reference yet, so a nonzero error cannot count as alternating
        alt      = (sg == ZERO) || (prev_sg != ZERO && sg != prev_sg);
        cnt_nx   = !alt ? '0 : (lock_cnt == CNT_W'(LOCK_N)) ? lock_cnt : lock_cnt + 1'b1;
    end
    always_ff @(posedge clk_err or negedge rstb) begin
        if (!rstb) begin
            acc      <= ACC_RST;
            mtune    <= ACC_RST[ACC_W-1 -: MTUNE_W];
            lock_cnt <= '0;
            prev_sg  <= ZERO;
            locked   <= 1'b0;
            sat_hi   <= 1'b0;
            sat_lo   <= 1'b0;
        end else if (en_ext_tune) begin
            acc      <= {ext_mtune, {FRAC_W{1'b0}}};
            mtune    <= ext_mtune;
            lock_cnt <= '0;
            prev_sg  <= ZERO;
            locked   <= 1'b0;
            sat_hi   <= 1'b0;
            sat_lo   <= 1'b0;
        end else if (err_valid && en_lf) begin
            acc      <= acc_nx;
            mtune    <= mt_nx;
            lock_cnt <= cnt_nx;
            prev_sg  <= sg;
            locked   <= (cnt_nx == CNT_W'(LOCK_N));
            sat_hi   <= clamp_hi;
            sat_lo   <= clamp_lo;
        end
    end
    assign lf_out = {mtune, acc[FRAC_W-1:0]};
    mdll_dsm1 #(.FRAC_W(FRAC_W)) u_dsm (
        .clk_err(clk_err),
        .rstb   (rstb),
        .frac   (acc[FRAC_W-1:0]),
        .en     (en_dith),
        .hold   (!en_lf),
        .dither (dither)
    );
endmodule

// File: tb/tb_mdll_lf_gen.sv
// tb_mdll_lf_gen: scoreboard bench for the MDLL loop filter with a behavioural integer model
module tb_mdll_lf_gen;
    logic        clk_err = 1'b0, rstb = 1'b0, en_lf = 1'b1, loop_sel = 1'b1, err_valid = 1'b0;
    logic        dout_bb = 1'b0, en_ext_tune = 1'b0, en_dith = 1'b0;
    logic [3:0]  tdc_err = '0, gain_ctrl = '0;
    logic [1:0]  gain_ratio = '0;
    logic [6:0]  ext_mtune = '0, mtune;
    logic [12:0] lf_out;
    logic        dither, locked, sat_hi, sat_lo;
    typedef struct {int lf; int mt; int hi; int lo; int lk;} exp_t;
    exp_t q[$];
    int   checks = 0, errors = 0;
    int   m_acc, m_mt, m_prev, m_cnt, m_hi, m_lo, m_lk, m_dsm;
    logic upd_seen = 1'b0;

    mdll_lf_gen dut (
        .clk_err(clk_err), .rstb(rstb), .en_lf(en_lf), .loop_sel(loop_sel), .err_valid(err_valid),
        .dout_bb(dout_bb), .tdc_err(tdc_err), .gain_ctrl(gain_ctrl), .gain_ratio(gain_ratio),
        .en_ext_tune(en_ext_tune), .ext_mtune(ext_mtune), .en_dith(en_dith), .mtune(mtune),
        .lf_out(lf_out), .dither(dither), .locked(locked), .sat_hi(sat_hi), .sat_lo(sat_lo)
    );

    always #5 clk_err = ~clk_err;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic m_clear(input int acc, input int mt);
        m_acc = acc; m_mt = mt; m_prev = 0; m_cnt = 0; m_hi = 0; m_lo = 0; m_lk = 0;
    endtask

    task automatic m_upd(input int e);
        int sh, s, sg, t;
        sh = (int'(gain_ctrl) > 12) ? 12 : int'(gain_ctrl);
        s = m_acc + e * (1 << sh);
        m_hi = (s > 8191) ? 1 : 0;
        m_lo = (s < 0) ? 1 : 0;
        m_acc = m_lo ? 0 : m_hi ? 8191 : s;
        sg = (e > 0) ? 1 : (e < 0) ? -1 : 0;
        t = m_acc / 64 + sg * int'(gain_ratio);
        m_mt = (t < 0) ? 0 : (t > 127) ? 127 : t;
        if (sg == 0 || (m_prev != 0 && sg != m_prev)) m_cnt = (m_cnt < 16) ? m_cnt + 1 : 16;
        else m_cnt = 0;
        m_prev = sg;
        m_lk = (m_cnt == 16) ? 1 : 0;
    endtask

    // drive one strobe at a negedge; the expected result is queued for the monitor
    task automatic upd(input bit sel, input bit bb, input int tdc);
        loop_sel = sel; dout_bb = bb; tdc_err = 4'(tdc); err_valid = 1'b1;
        if (en_lf && !en_ext_tune && rstb) begin
            m_upd(sel ? (bb ? 1 : -1) : tdc);
            q.push_back('{m_mt * 64 + m_acc % 64, m_mt, m_hi, m_lo, m_lk});
        end
        @(negedge clk_err);
        err_valid = 1'b0;
    endtask

    task automatic ext(input int v, input bit strobe);
        en_ext_tune = 1'b1; ext_mtune = 7'(v); err_valid = strobe; dout_bb = 1'b0; loop_sel = 1'b1;
        m_clear(v * 64, v);
        @(negedge clk_err);
        en_ext_tune = 1'b0; err_valid = 1'b0;
        chk("ext_mtune", int'(mtune), v);
        chk("ext_lf", int'(lf_out), v * 64);
        chk("ext_sat", int'({sat_hi, sat_lo}), 0);
    endtask

    task automatic do_reset;
        #2 rstb = 1'b0;
        #1 chk("async_rst_mtune", int'(mtune), 64);
        q.delete();
        m_clear(4096, 64);
        m_dsm = 0;
        @(negedge clk_err);
        rstb = 1'b1;
    endtask

    always @(posedge clk_err) upd_seen <= err_valid && en_lf && !en_ext_tune && rstb;

    always @(negedge clk_err) begin : mon
        exp_t x;
        if (upd_seen) begin
            if (q.size() == 0) chk("sb_underflow", q.size(), 1);
            else begin
                x = q.pop_front();
                chk("sb_lf", int'(lf_out), x.lf);
                chk("sb_mtune", int'(mtune), x.mt);
                chk("sb_sat_hi", int'(sat_hi), x.hi);
                chk("sb_sat_lo", int'(sat_lo), x.lo);
                chk("sb_locked", int'(locked), x.lk);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        m_clear(4096, 64);
        m_dsm = 0;
        repeat (3) @(negedge clk_err);
        chk("rst_mtune", int'(mtune), 64);
        chk("rst_lf", int'(lf_out), 4096);
        chk("rst_dither", int'(dither), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_sat", int'({sat_hi, sat_lo}), 0);
        rstb = 1'b1;
        @(negedge clk_err);
        repeat (64) upd(1, 1, 0);
        chk("bb64_lf", int'(lf_out), 4160);
        chk("bb64_mtune", int'(mtune), 65);

        do_reset();
        gain_ratio = 2;
        upd(1, 1, 0);
        chk("ratio_mtune", int'(mtune), 66);
        chk("ratio_frac", int'(lf_out[5:0]), 1);

        gain_ratio = 0;
        ext(127, 0);
        gain_ctrl = 6;
        upd(1, 1, 0);
        chk("sat_hi_set", int'(sat_hi), 1);
        chk("sat_hi_lf", int'(lf_out), 8191);
        chk("sat_hi_mtune", int'(mtune), 127);
        upd(1, 0, 0);
        chk("sat_hi_clr", int'(sat_hi), 0);
        chk("sat_hi_clr_lf", int'(lf_out), 8127);

        // a strobe during override must not seed the previous sign
        gain_ctrl = 0;
        ext(64, 1);
        for (int i = 0; i < 17; i++) begin
            upd(1, (i % 2) == 0, 0);
            if (i == 15) chk("lock_16", int'(locked), 0);
        end
        chk("lock_17", int'(locked), 1);
        upd(1, 1, 0);
        chk("lock_lost", int'(locked), 0);

        do_reset();
        gain_ctrl = 5;
        upd(1, 1, 0);
        chk("dith_frac", int'(lf_out[5:0]), 32);
        en_dith = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_err);
            m_dsm = m_dsm + m_acc % 64;
            chk("dither_seq", int'(dither), (m_dsm >= 64) ? 1 : 0);
            m_dsm = m_dsm % 64;
        end
        en_lf = 1'b0;
        upd(1, 1, 0);
        @(negedge clk_err);
        chk("hold_dither", int'(dither), 1);
        chk("hold_lf", int'(lf_out), m_mt * 64 + m_acc % 64);
        en_lf = 1'b1;
        en_dith = 1'b0;
        @(negedge clk_err);
        chk("dith_off", int'(dither), 0);

        do_reset();
        gain_ratio = 1;
        ext(0, 0);
        gain_ctrl = 15;
        upd(0, 0, -8);
        chk("tdc_sat_lo", int'(sat_lo), 1);
        chk("tdc_mtune", int'(mtune), 0);
        chk("tdc_lf", int'(lf_out), 0);
        upd(0, 0, 3);
        loop_sel = 1'b1; dout_bb = 1'b1; err_valid = 1'b1;
        do_reset();
        err_valid = 1'b0;
        @(negedge clk_err);
        chk("no_stale_upd", int'(lf_out), 4096);

        for (int n = 0; n < 400; n++) begin
            gain_ctrl = 4'($urandom_range(0, 15));
            gain_ratio = 2'($urandom_range(0, 3));
            en_lf = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 39) == 0) ext(int'($urandom_range(0, 127)), 1'($urandom_range(0, 1)));
            else if ($urandom_range(0, 4) == 0) @(negedge clk_err);
            else upd(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)) - 8);
        end
        en_lf = 1'b1;
        @(negedge clk_err);
        chk("sb_drain", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mdll_lf_gen.md
MDLL_LF_GEN -- requirements
Module: mdll_lf_gen

Interface
REQ-001 Parameter MTUNE_W, default 7, coarse/fine tune code width driven to the oscillator.
REQ-002 Parameter FRAC_W, default 6, fractional integrator bits feeding the dither modulator.
REQ-003 Parameter TDC_W, default 4, signed TDC error word width.
REQ-004 Parameter GAIN_W, default 4, integral gain-shift control width.
REQ-005 Parameter LOCK_N, default 16, consecutive qualifying updates required for lock.
REQ-006 Port clk_err, input, 1, loop clock; one clock only; all state on its rising edge.
REQ-007 Port rstb, input, 1, asynchronous active-low reset.
REQ-008 Port en_lf, input, 1, loop enable; 0 freezes all loop state.
REQ-009 Port loop_sel, input, 1, 1 = BB error (dout_bb), 0 = TDC error (tdc_err).
REQ-010 Port err_valid, input, 1, one-cycle strobe qualifying dout_bb/tdc_err.
REQ-011 Port dout_bb, input, 1, BB phase decision: 1 = +1, 0 = -1.
REQ-012 Port tdc_err, input, TDC_W, two's-complement TDC error.
REQ-013 Port gain_ctrl, input, GAIN_W, integral shift.
REQ-014 Port gain_ratio, input, 2, proportional gain in mtune LSBs (0..3).
REQ-015 Port en_ext_tune / ext_mtune, input, 1 / MTUNE_W, external tune override.
REQ-016 Port en_dith, input, 1, enable first-order DSM dither.
REQ-017 Port mtune, output, MTUNE_W, registered tune code.
REQ-018 Port lf_out, output, MTUNE_W+FRAC_W, {mtune, acc fractional bits}.
REQ-019 Port dither / locked / sat_hi / sat_lo, output, 1 each, registered.

Function
REQ-020 Integrator acc SHALL be unsigned, ACC_W = MTUNE_W+FRAC_W bits; top MTUNE_W bits = acc_top, low FRAC_W bits = frac.
REQ-021 Error e SHALL be +1/-1 from dout_bb when loop_sel=1, sign-extended tdc_err when loop_sel=0; sgn(e) in {-1,0,+1}.
REQ-022 On a cycle with err_valid=1, en_lf=1, en_ext_tune=0: acc_next = clamp(acc + (e << min(gain_ctrl, ACC_W-1)), 0, 2^ACC_W-1), computed in ACC_W+TDC_W+1 signed bits, no intermediate wrap.
REQ-023 Same cycle: mtune <= clamp(acc_next_top + sgn(e)*gain_ratio, 0, 2^MTUNE_W-1); mtune holds between updates; latency from err_valid to new mtune/acc = 1 clock.
REQ-024 sat_hi (sat_lo) SHALL be set on an update where the integrator clamped at max (min), cleared on the next non-clamping update; held otherwise.
REQ-025 en_ext_tune=1 (priority over errors) SHALL load acc <= {ext_mtune, 0} and mtune <= ext_mtune every cycle, clear lock_cnt, sat flags; on deassertion loop resumes from that value (bumpless).
REQ-026 en_lf=0 with en_ext_tune=0 SHALL hold acc, mtune, DSM state, lock_cnt, flags; dither held at last value.
REQ-027 DSM: when en_dith=1 and en_lf=1, each clock dsm <= (dsm + frac) mod 2^FRAC_W, dither <= carry out; en_dith=0 clears dsm and dither to 0.
REQ-028 Lock: on each qualifying update (REQ-022 condition) lock_cnt increments (saturating at LOCK_N) if sgn(e)=0 or sgn(e) != previous update's sgn(e), else clears to 0; first update after reset/ext tune counts as non-alternating.
REQ-029 locked SHALL equal (lock_cnt == LOCK_N), registered.
REQ-030 err_valid coincident with en_ext_tune=1 SHALL be ignored entirely (previous sign not updated).

Reset
REQ-031 rstb=0 SHALL asynchronously set acc = 2^(ACC_W-1) (mtune = 2^(MTUNE_W-1) = 64 default, frac = 0), dsm = 0, dither = 0, lock_cnt = 0, previous sign = 0, locked = 0, sat_hi = sat_lo = 0.
REQ-032 Reset deassertion mid-operation SHALL resume from reset values; no pending update survives reset.

Structure
REQ-033 Shared package mdll_pkg SHALL hold the loop_sel encoding constants, sign enum (NEG/ZERO/POS) and the clamp/width-derivation constants.
REQ-034 DSM SHALL be a sub-module mdll_dsm1 (FRAC_W parameter, frac in, en, dither out); rest in mdll_lf_gen.

Verification
REQ-035 Reset, BB, gain_ctrl=0, gain_ratio=0, 64 updates dout_bb=1 -> acc=4160, mtune=65, lf_out=65<<6.
REQ-036 From reset, gain_ratio=2, one update dout_bb=1, gain_ctrl=0 -> acc=4097, mtune=66 one clock after strobe.
REQ-037 ext_mtune=127 pulse then release; gain_ctrl=6, update dout_bb=1 -> acc=8191, mtune=127, sat_hi=1; next update dout_bb=0 -> sat_hi=0, acc=8127.
REQ-038 From reset, gain_ctrl=5, one +1 update (frac=32), en_dith=1 -> dither alternates 0,1,0,1 (50% duty).
REQ-039 BB alternating 1,0,1,... for 17 updates -> locked=1 after 17th; one repeated sign -> locked=0 next clock.
REQ-040 TDC mode tdc_err=-8 at acc=0, gain_ctrl=15 -> clamp shift 12, acc=0, sat_lo=1, mtune=0; rstb asserted mid-run -> mtune=64 immediately.
